// File: rtl/uart_tx_fsm_ctrl_if.sv
// Handshake/control bundle between the UART Tx frame sequencer and its
// requester / datapath. Sequencer side uses the slave modport.
interface uart_tx_fsm_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic          Data_Valid;
    logic          PAR_EN;
    logic          load_en;
    logic          ser_en;
    logic [IW-1:0] bit_idx;
    logic [1:0]    mux_sel;
    logic          busy;

    modport master (
        output Data_Valid, PAR_EN,
        input  load_en, ser_en, bit_idx, mux_sel, busy
    );

    modport slave (
        input  Data_Valid, PAR_EN,
        output load_en, ser_en, bit_idx, mux_sel, busy
    );
endinterface

// File: rtl/uart_tx_fsm_ctrl.sv
// UART Tx frame sequencer: start, DATA_WIDTH data bits LSB first, optional
// parity, stop. One bit per CLK. Outputs other than load_en are registered
// alongside the state so they never depend on the current inputs.
module uart_tx_fsm_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_fsm_ctrl_if.slave bus
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_IDLE   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    // 3-bit encoding leaves spare codes; those fall into the default arm.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_bit_cnt;
    logic          r_par_en_q;
    logic [1:0]    r_mux_sel;
    logic          r_ser_en;
    logic          r_busy;
    logic          w_idle;

    assign w_idle = (r_state == IDLE);

    // Only input-to-output path: load strobe follows the request while idle.
    assign bus.load_en = bus.Data_Valid & w_idle;
    assign bus.ser_en  = r_ser_en;
    assign bus.bit_idx = r_bit_cnt;
    assign bus.mux_sel = r_mux_sel;
    assign bus.busy    = r_busy;

    // Frame sequencing; output registers are loaded with the value of the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_par_en_q <= 1'b0;
            r_mux_sel  <= MUX_IDLE;
            r_ser_en   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.Data_Valid) begin
                        r_state    <= START;
                        r_par_en_q <= bus.PAR_EN;
                        r_mux_sel  <= MUX_START;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    r_state   <= DATA;
                    r_bit_cnt <= '0;
                    r_mux_sel <= MUX_DATA;
                    r_ser_en  <= 1'b1;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_ser_en  <= 1'b0;
                        if (r_par_en_q) begin
                            r_state   <= PARITY;
                            r_mux_sel <= MUX_PARITY;
                        end else begin
                            r_state   <= STOP;
                            r_mux_sel <= MUX_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    r_state   <= STOP;
                    r_mux_sel <= MUX_IDLE;
                end
                STOP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    r_mux_sel <= MUX_IDLE;
                    r_ser_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
// Scoreboard bench for the UART Tx frame sequencer. Stimulus pushes the
// per-cycle expected line of each accepted frame; a monitor pops one entry
// per cycle (or expects idle when nothing is queued).
module tb_uart_tx_fsm_ctrl;
    logic CLK = 1'b0;
    logic RST;

    uart_tx_fsm_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_fsm_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mux;
        logic       busy;
        logic       ser;
        logic [2:0] idx;
        logic       tx;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: a frame is start 0, data LSB first, optional parity, stop 1.
    task automatic push_frame(input logic [7:0] d, input logic p_en, input logic p_typ);
        exp_t e;
        logic par;
        par = p_typ ? ~(^d) : (^d);
        e.data = d; e.par = par;
        e.mux = 2'b00; e.busy = 1; e.ser = 0; e.idx = 0; e.tx = 0;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.mux = 2'b10; e.ser = 1; e.idx = 3'(i); e.tx = d[i];
            exp_q.push_back(e);
        end
        e.ser = 0; e.idx = 0;
        if (p_en) begin
            e.mux = 2'b11; e.tx = par;
            exp_q.push_back(e);
        end
        e.mux = 2'b01; e.tx = 1;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        logic tx_act;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (bus.mux_sel)
                    2'b00:   tx_act = 1'b0;
                    2'b01:   tx_act = 1'b1;
                    2'b10:   tx_act = e.data[bus.bit_idx];
                    default: tx_act = e.par;
                endcase
                chk("frame_busy", int'(bus.busy), int'(e.busy));
                chk("frame_mux", int'(bus.mux_sel), int'(e.mux));
                chk("frame_ser_en", int'(bus.ser_en), int'(e.ser));
                if (e.ser) chk("frame_bit_idx", int'(bus.bit_idx), int'(e.idx));
                chk("frame_tx", int'(tx_act), int'(e.tx));
            end else begin
                chk("idle_busy", int'(bus.busy), 0);
                chk("idle_mux", int'(bus.mux_sel), 1);
                chk("idle_ser_en", int'(bus.ser_en), 0);
                chk("idle_bit_idx", int'(bus.bit_idx), 0);
            end
        end
    end

    // Issue a request on the first idle cycle seen; bounded wait.
    task automatic request(input logic [7:0] d, input logic p_en, input logic p_typ);
        int n;
        n = 0;
        @(negedge CLK);
        while (bus.busy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) chk("wait_idle_timeout", 1, 0);
        bus.Data_Valid = 1'b1;
        bus.PAR_EN     = p_en;
        #1;
        chk("load_en_accept", int'(bus.load_en), 1);
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = $urandom_range(0, 1);
        push_frame(d, p_en, p_typ);
    endtask

    initial begin
        int n;
        RST = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;

        // 1: reset then quiet idle
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        #1 chk("reset_load_en", int'(bus.load_en), 0);
        repeat (4) @(posedge CLK);

        // 2: no parity, 0xA5
        request(8'hA5, 1'b0, 1'b0);
        repeat (13) @(posedge CLK);

        // 3: parity even then odd on 0x07
        request(8'h07, 1'b1, 1'b0);
        request(8'h07, 1'b1, 1'b1);

        // 4: request during DATA bit 2 ignored, PAR_EN flip ignored
        request(8'h5A, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b1;
        bus.PAR_EN     = 1'b0;
        #1 chk("busy_load_en", int'(bus.load_en), 0);
        @(posedge CLK);
        #1 bus.Data_Valid = 1'b0;

        // 5: reset at DATA bit 4, then fresh frame
        request(8'h3C, 1'($urandom_range(0, 1)), 1'b0);
        repeat (5) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        exp_q.delete();
        #1 RST = 1'b1;
        request(8'hC3, 1'b1, 1'b1);

        // reset coincident with request: strobe still seen, request dropped
        n = 0;
        @(negedge CLK);
        while (bus.busy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) chk("wait_idle_timeout", 1, 0);
        RST = 1'b0;
        bus.Data_Valid = 1'b1;
        #1 chk("reset_req_load_en", int'(bus.load_en), 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        bus.Data_Valid = 1'b0;
        repeat (2) @(posedge CLK);

        // 6: five back-to-back random frames
        for (int f = 0; f < 5; f++)
            request(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 1, 0);
        repeat (3) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
